render_mtx_scheduler: RTL and testbench
=======================================

// Module: render_mtx_scheduler
// PURPOSE
//  Frame-synchronous scheduler for the render transform path. Two requesters
//  (A: user-input transform, B: animation sequencer) submit 4x4 Q-format vertex
//  matrices plus a matrix state. A round-robin arbiter accepts one into a
//  pending buffer. The buffer commits to the active matrix feeding the render
//  datapath only at a fixed blanking line, so a frame never tears mid-scan.
// PARAMETERS
//  MTX_W          336  active/pending matrix width (16 x 21-bit signed)
//  ST_W           4    matrix-state width
//  V_COMMIT       480  v_cnt line on which a pending update commits (first blank line)
//  SETTLE_CYCLES  16   pclk cycles render_ready stays low after a commit (>=1)
// PORTS
//  pclk         in   1      pixel clock; all logic on rising edge
//  rst          in   1      asynchronous, active-high reset
//  h_cnt        in   10     VGA horizontal counter
//  v_cnt        in   10     VGA vertical counter
//  req          in   2      [0]=A, [1]=B; level request, held until own gnt bit seen
//  mtrx_a       in   MTX_W  requester A matrix; stable while req[0]=1
//  state_a      in   ST_W   requester A matrix state
//  mtrx_b       in   MTX_W  requester B matrix; stable while req[1]=1
//  state_b      in   ST_W   requester B matrix state
//  gnt          out  2      one-cycle acceptance pulse, one-hot or zero
//  mtrx_out     out  MTX_W  active matrix to the render datapath
//  state_out    out  ST_W   active matrix state
//  render_ready out  1      active matrix committed and settled
//  frame_tick   out  1      one-cycle pulse on every commit event
//  ovr_cnt      out  8      overwritten-update count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; gnt=0, mtrx_out=0, state_out=0, render_ready=0,
//    frame_tick=0, ovr_cnt=0, pending=0, RR pointer favours A.
//  - commit_evt = (v_cnt==V_COMMIT && h_cnt==0), combinational from the inputs.
//  - frame_tick registered: high the cycle after any edge sampling commit_evt, in every state.
//  - FSM: IDLE, PENDING, SETTLE.
//    IDLE: grant -> capture pending, go PENDING. commit_evt has no effect.
//    PENDING: grant -> pending overwritten (latest wins), stay PENDING.
//      commit_evt -> mtrx_out/state_out <= pending on that edge, render_ready<=0,
//      cnt<=SETTLE_CYCLES-1, go SETTLE.
//    SETTLE: no grants. Decrement cnt each cycle. At cnt==0 -> render_ready<=1, go IDLE.
//  - Arbitration runs only in IDLE/PENDING and only on edges without commit_evt.
//    Commit has priority; losing requester keeps req and is served later.
//  - Eligible = req bit set AND own gnt bit currently low. This prevents a double grant
//    while the requester drops req.
//  - One eligible -> grant it. Both eligible -> grant the one not granted last.
//    Pointer updates on each grant.
//  - gnt registered: the same edge sets gnt[i]=1 and captures mtrx_i/state_i into pending.
//  - Commit latency: commit_evt edge -> mtrx_out valid next cycle.
//    render_ready returns SETTLE_CYCLES cycles after the commit edge.
//  - A grant on the edge immediately before commit_evt is committed in that frame.
//  - rst mid-SETTLE/PENDING: pending discarded, all outputs to reset values at once.
//  - v_cnt never matching V_COMMIT: pending held indefinitely; no timeout.
// CONFIGURATION
//  - RENDER_SCHED_OVR_CNT_EN defined:
//    ovr_cnt +1 (saturating at 255) on each grant taken in PENDING.
//    Counts updates overwritten before commit. Cleared only by rst.
//  - Not defined: ovr_cnt tied to 8'd0; no counter logic.
// TESTING
//  1 Reset: rst pulse -> all outputs 0, FSM IDLE. commit_evt while IDLE -> frame_tick
//    pulse only, mtrx_out stays 0.
//  2 req=01, mtrx_a=M1, state_a=4'h3. Then reach v=480,h=0 -> gnt=01 for exactly 1 cycle.
//    mtrx_out=M1/4'h3 the cycle after commit. render_ready=1 16 cycles after the commit edge.
//  3 req=11 held from IDLE -> gnt 01 then 10 on consecutive accepting edges, never 11.
//    B's matrix is the one committed. Overwrite case: with macro, ovr_cnt=1.
//  4 Pending held, req=10 asserted on the commit_evt edge -> no gnt that edge, commit wins.
//    B not granted during SETTLE; gnt=10 on the first IDLE edge.
//  5 rst asserted mid-SETTLE (cnt=7) -> mtrx_out=0, render_ready=0, no further gnt/frame_tick.
//  6 300 grants without commit, macro defined -> ovr_cnt saturates at 255.
//    Macro undefined -> ovr_cnt=0 throughout.

Source files
------------

// File: rtl/render_mtx_scheduler.sv
// Frame-synchronous matrix scheduler: round-robin accepts A/B updates into a pending
// buffer that commits to the active matrix only on the blanking line. Optional macro:
// RENDER_SCHED_OVR_CNT_EN enables the overwritten-update counter on ovr_cnt.
module render_mtx_scheduler #(
    parameter int unsigned MTX_W         = 336,
    parameter int unsigned ST_W          = 4,
    parameter int unsigned V_COMMIT      = 480,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [9:0]       h_cnt,
    input  logic [9:0]       v_cnt,
    input  logic [1:0]       req,
    input  logic [MTX_W-1:0] mtrx_a,
    input  logic [ST_W-1:0]  state_a,
    input  logic [MTX_W-1:0] mtrx_b,
    input  logic [ST_W-1:0]  state_b,
    output logic [1:0]       gnt,
    output logic [MTX_W-1:0] mtrx_out,
    output logic [ST_W-1:0]  state_out,
    output logic             render_ready,
    output logic             frame_tick,
    output logic [7:0]       ovr_cnt
);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_SETTLE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_b_q, last_b_d;
    logic [MTX_W-1:0]   pend_mtx_q, pend_mtx_d;
    logic [ST_W-1:0]    pend_st_q, pend_st_d;
    logic [MTX_W-1:0]   mtrx_out_q, mtrx_out_d;
    logic [ST_W-1:0]    state_out_q, state_out_d;
    logic               ready_q, ready_d;
    logic               frame_tick_q, frame_tick_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               commit_evt_c;
    logic               arb_en_c;
    logic [1:0]         elig_c;
    logic [1:0]         gnt_sel_c;

    assign commit_evt_c = (v_cnt == 10'(V_COMMIT)) && (h_cnt == 10'd0);

    // Arbitration: a requester whose grant pulse is still visible is not eligible.
    assign arb_en_c = (state_q != S_SETTLE) && !commit_evt_c;
    assign elig_c   = req & ~gnt_q;

    always_comb begin
        gnt_sel_c = 2'b00;
        if (arb_en_c) begin
            case (elig_c)
                2'b01:   gnt_sel_c = 2'b01;
                2'b10:   gnt_sel_c = 2'b10;
                2'b11:   gnt_sel_c = last_b_q ? 2'b01 : 2'b10;
                default: gnt_sel_c = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_sel_c;
        last_b_d     = last_b_q;
        pend_mtx_d   = pend_mtx_q;
        pend_st_d    = pend_st_q;
        mtrx_out_d   = mtrx_out_q;
        state_out_d  = state_out_q;
        ready_d      = ready_q;
        frame_tick_d = commit_evt_c;
        cnt_d        = cnt_q;

        if (gnt_sel_c != 2'b00) begin
            last_b_d   = gnt_sel_c[1];
            pend_mtx_d = gnt_sel_c[1] ? mtrx_b : mtrx_a;
            pend_st_d  = gnt_sel_c[1] ? state_b : state_a;
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_sel_c != 2'b00) state_d = S_PENDING;
            end
            S_PENDING: begin
                // Commit edges never grant, so the buffer read here is stable.
                if (commit_evt_c) begin
                    mtrx_out_d  = pend_mtx_q;
                    state_out_d = pend_st_q;
                    ready_d     = 1'b0;
                    cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            last_b_q     <= 1'b1;
            pend_mtx_q   <= '0;
            pend_st_q    <= '0;
            mtrx_out_q   <= '0;
            state_out_q  <= '0;
            ready_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_b_q     <= last_b_d;
            pend_mtx_q   <= pend_mtx_d;
            pend_st_q    <= pend_st_d;
            mtrx_out_q   <= mtrx_out_d;
            state_out_q  <= state_out_d;
            ready_q      <= ready_d;
            frame_tick_q <= frame_tick_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef RENDER_SCHED_OVR_CNT_EN
    // Counts updates that replaced a still-uncommitted pending matrix.
    logic       ovr_inc_c;
    logic [7:0] ovr_q, ovr_d;

    assign ovr_inc_c = (state_q == S_PENDING) && (gnt_sel_c != 2'b00);

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_inc_c && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) ovr_q <= 8'd0;
        else     ovr_q <= ovr_d;
    end

    assign ovr_cnt = ovr_q;
`else
    assign ovr_cnt = 8'd0;
`endif

    assign gnt          = gnt_q;
    assign mtrx_out     = mtrx_out_q;
    assign state_out    = state_out_q;
    assign render_ready = ready_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_render_mtx_scheduler.sv
// Directed bench for render_mtx_scheduler: reset, single update, round-robin overwrite,
// commit priority, reset during settle and overwrite-counter saturation.
module tb_render_mtx_scheduler;
    localparam int unsigned MTX_W = 336;
    localparam int unsigned ST_W  = 4;

    logic             pclk = 1'b0;
    logic             rst;
    logic [9:0]       h_cnt, v_cnt;
    logic [1:0]       req;
    logic [MTX_W-1:0] mtrx_a, mtrx_b;
    logic [ST_W-1:0]  state_a, state_b;
    logic [1:0]       gnt;
    logic [MTX_W-1:0] mtrx_out;
    logic [ST_W-1:0]  state_out;
    logic             render_ready, frame_tick;
    logic [7:0]       ovr_cnt;

    logic [MTX_W-1:0] m1, m2, m3, m4, m5;
    int checks = 0;
    int failures = 0;

    render_mtx_scheduler dut (
        .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .req(req),
        .mtrx_a(mtrx_a), .state_a(state_a), .mtrx_b(mtrx_b), .state_b(state_b),
        .gnt(gnt), .mtrx_out(mtrx_out), .state_out(state_out),
        .render_ready(render_ready), .frame_tick(frame_tick), .ovr_cnt(ovr_cnt)
    );

    always #5 pclk = ~pclk;

    // Advance one edge; requesters drop req once they see their grant.
    task automatic tick();
        @(posedge pclk);
        #1;
        req = req & ~gnt;
    endtask

    task automatic set_line(input bit commit);
        v_cnt = commit ? 10'd480 : 10'd10;
        h_cnt = commit ? 10'd0 : 10'd5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] exp_ovr(input int n);
`ifdef RENDER_SCHED_OVR_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return (n >= 0) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        set_line(1'b0);
        tick();
        checks++;
        if ({gnt, mtrx_out, state_out, render_ready, frame_tick, ovr_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b rr=%b ft=%b st=%h ovr=%0d, required all 0",
                     gnt, render_ready, frame_tick, state_out, ovr_cnt);
        end
        rst = 1'b0;
        tick();
        set_line(1'b1);
        tick();
        set_line(1'b0);
        checks++;
        if (frame_tick !== 1'b1 || mtrx_out !== '0 || render_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_commit: ft=%b mtx_zero=%b rr=%b, required ft=1 mtx_zero=1 rr=0",
                     frame_tick, mtrx_out == '0, render_ready);
        end
        tick();
        checks++;
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL idle_tick_width: frame_tick=%b, required 0", frame_tick);
        end
    endtask

    task automatic test_single();
        mtrx_a = m1;
        state_a = 4'h3;
        req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL single_gnt: gnt=%b, required 01", gnt);
        end
        mtrx_a = m2;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("FAIL single_gnt_width: gnt=%b, required 00", gnt);
        end
        set_line(1'b1);
        tick();
        set_line(1'b0);
        checks++;
        if (mtrx_out !== m1 || state_out !== 4'h3 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL single_commit: mtx_ok=%b st=%h ft=%b, required mtx_ok=1 st=3 ft=1",
                     mtrx_out === m1, state_out, frame_tick);
        end
        for (int i = 1; i < 16; i++) tick();
        checks++;
        if (render_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_settle_early: render_ready=%b after 15 cycles, required 0", render_ready);
        end
        tick();
        checks++;
        if (render_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_settle_done: render_ready=%b after 16 cycles, required 1", render_ready);
        end
    endtask

    task automatic test_rr_overwrite();
        do_reset();
        mtrx_a = m2; state_a = 4'h5;
        mtrx_b = m3; state_b = 4'h9;
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rr_first: gnt=%b, required 01", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL rr_second: gnt=%b, required 10", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b00 || ovr_cnt !== exp_ovr(1)) begin
            failures++;
            $display("FAIL rr_after: gnt=%b ovr=%0d, required gnt=00 ovr=%0d", gnt, ovr_cnt, exp_ovr(1));
        end
        set_line(1'b1);
        tick();
        set_line(1'b0);
        checks++;
        if (mtrx_out !== m3 || state_out !== 4'h9) begin
            failures++;
            $display("FAIL rr_commit: mtx_is_b=%b st=%h, required mtx_is_b=1 st=9", mtrx_out === m3, state_out);
        end
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (render_ready !== 1'b1) begin
            failures++;
            $display("FAIL rr_settle: render_ready=%b, required 1", render_ready);
        end
    endtask

    task automatic test_commit_priority();
        int bad;
        mtrx_a = m4; state_a = 4'h1;
        req = 2'b01;
        tick();
        tick();
        mtrx_b = m5; state_b = 4'h2;
        req = 2'b10;
        set_line(1'b1);
        tick();
        set_line(1'b0);
        checks++;
        if (gnt !== 2'b00 || mtrx_out !== m4 || state_out !== 4'h1 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL prio_commit: gnt=%b mtx_is_a=%b st=%h ft=%b, required 00/1/1/1",
                     gnt, mtrx_out === m4, state_out, frame_tick);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (gnt !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0 || render_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_settle: grants_in_settle=%0d rr=%b, required 0 and rr=1", bad, render_ready);
        end
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL prio_idle_gnt: gnt=%b, required 10", gnt);
        end
    endtask

    task automatic test_reset_settle();
        int bad;
        set_line(1'b1);
        tick();
        set_line(1'b0);
        checks++;
        if (mtrx_out !== m5 || state_out !== 4'h2) begin
            failures++;
            $display("FAIL rst_settle_commit: mtx_is_b=%b st=%h, required 1 and 2", mtrx_out === m5, state_out);
        end
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (mtrx_out !== '0 || state_out !== '0 || render_ready !== 1'b0 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL rst_settle_async: mtx_zero=%b st=%h rr=%b gnt=%b, required 1/0/0/00",
                     mtrx_out == '0, state_out, render_ready, gnt);
        end
        tick();
        rst = 1'b0;
        req = 2'b00;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt !== 2'b00 || frame_tick !== 1'b0 || render_ready !== 1'b0 || mtrx_out !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_settle_quiet: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_ovr_sat();
        int grants;
        int bad;
        do_reset();
        grants = 0;
        bad = 0;
        mtrx_a = m1; mtrx_b = m2;
        for (int i = 1; i <= 300; i++) begin
            req = 2'b11;
            tick();
            if (gnt == 2'b01 || gnt == 2'b10) grants++;
            else bad++;
            if (i == 100) begin
                checks++;
                if (ovr_cnt !== exp_ovr(99)) begin
                    failures++;
                    $display("FAIL ovr_mid: ovr_cnt=%0d, required %0d", ovr_cnt, exp_ovr(99));
                end
            end
            if (i == 256) begin
                checks++;
                if (ovr_cnt !== exp_ovr(255)) begin
                    failures++;
                    $display("FAIL ovr_reach: ovr_cnt=%0d, required %0d", ovr_cnt, exp_ovr(255));
                end
            end
        end
        req = 2'b00;
        tick();
        checks++;
        if (grants != 300 || bad != 0) begin
            failures++;
            $display("FAIL ovr_grants: grants=%0d bad_cycles=%0d, required 300 and 0", grants, bad);
        end
        checks++;
        if (ovr_cnt !== exp_ovr(299) || mtrx_out !== '0) begin
            failures++;
            $display("FAIL ovr_sat: ovr_cnt=%0d mtx_zero=%b, required %0d and 1",
                     ovr_cnt, mtrx_out == '0, exp_ovr(299));
        end
    endtask

    initial begin
        m1 = {16{21'h15A5A5}};
        m2 = {16{21'h0F0F0F}};
        m3 = {16{21'h1C3C3C}};
        m4 = {16{21'h012345}};
        m5 = {16{21'h1FEDCB}};
        rst = 1'b1;
        req = 2'b00;
        mtrx_a = '0; mtrx_b = '0;
        state_a = '0; state_b = '0;
        set_line(1'b0);
        test_reset();
        test_single();
        test_rr_overwrite();
        test_commit_priority();
        test_reset_settle();
        test_ovr_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
